psram_dma_agen: RTL

Parametrised DMA address generator and RAM request sequencer for the PSRAM transfer path, in the hclk domain. Replaces the fixed linear-wrap address counter of the current transfer top with programmable stride, a ring window, a word counter, abort and completion signalling. Drives the RAM read port for PSRAM writes (tx) and the RAM write port for PSRAM reads (rx), paced by the tx/rx buffer's ready indication.

---
 rtl/psram_dma_agen.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/psram_dma_agen.sv
// ============================================================================
// Module   : psram_dma_agen
// Purpose  : DMA address generator and RAM request sequencer for the PSRAM
//            transfer path (hclk domain). Produces a programmable-stride word
//            address sequence over a transfer of 'len' words, optionally
//            folded into a ring window. Issues one RAM request per word,
//            paced by the tx/rx buffer ready indication, and signals
//            completion, abort and illegal-length errors.
// Revision : 1.0 - initial release
//
// Build option:
//   PSRAM_AGEN_WRAP_EN  defined   -> ring window of 'wrap_len' words
//                       undefined -> wrap_len ignored, offset wraps mod 2^AW
//
// Ports:
//   hclk, hrstn            clock, asynchronous active-low reset
//   start                  one-cycle start pulse (accepted only in IDLE)
//   abort                  level, stops issuing new requests
//   dir                    1 = tx (RAM read), 0 = rx (RAM write)
//   saddr [AW]             start word address
//   len [LW]               transfer length in words (0 is illegal)
//   wrap_len [LW]          ring window size in words (0 = no ring)
//   stride [SW]            address increment (0 behaves as 1)
//   buf_rdy                buffer can take/supply one word
//   ram_rd_req/ram_rd_ack  RAM read request / accept (dir = 1)
//   ram_wr_req/ram_wr_ack  RAM write request / accept (dir = 0)
//   ram_addr [AW]          current RAM word address
//   xfer_cnt [LW]          words completed
//   busy                   high while running or draining
//   done                   one-cycle completion pulse
//   aborted                transfer ended by abort (held until next start)
//   err                    one-cycle pulse on start with len == 0
// ============================================================================

`default_nettype none

module psram_dma_agen #(
  parameter int unsigned AW = 10,
  parameter int unsigned LW = 15,
  parameter int unsigned SW = 4
) (
  input  logic          hclk,
  input  logic          hrstn,
  input  logic          start,
  input  logic          abort,
  input  logic          dir,
  input  logic [AW-1:0] saddr,
  input  logic [LW-1:0] len,
  input  logic [LW-1:0] wrap_len,
  input  logic [SW-1:0] stride,
  input  logic          buf_rdy,
  output logic          ram_rd_req,
  input  logic          ram_rd_ack,
  output logic          ram_wr_req,
  input  logic          ram_wr_ack,
  output logic [AW-1:0] ram_addr,
  output logic [LW-1:0] xfer_cnt,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          err
);

  // Offset width: the ring window needs the full length range; without the
  // ring the offset only has to cover the RAM address space.
`ifdef PSRAM_AGEN_WRAP_EN
  localparam int unsigned OW = LW;
`else
  localparam int unsigned OW = AW;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q,   state_d;
  logic          dir_q,     dir_d;
  logic [AW-1:0] saddr_q,   saddr_d;
  logic [LW-1:0] len_q,     len_d;
  logic [SW-1:0] stride_q,  stride_d;
  logic [OW-1:0] off_q,     off_d;
  logic [LW-1:0] cnt_q,     cnt_d;
  logic          rd_req_q,  rd_req_d;
  logic          wr_req_q,  wr_req_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          aborted_q, aborted_d;
  logic          err_q,     err_d;
`ifdef PSRAM_AGEN_WRAP_EN
  logic [LW-1:0] wrap_q,    wrap_d;
`else
  logic          wrap_len_unused;
  assign wrap_len_unused = ^wrap_len;
`endif

  // Combined view of the active request and the ack for the latched direction.
  logic          req_cur;
  logic          ack_cur;
  logic          req_nxt;
  logic [LW-1:0] cnt_inc;
  logic          last_word;
  logic          remaining;
  logic [OW-1:0] off_adv;

  assign req_cur   = rd_req_q | wr_req_q;
  assign ack_cur   = dir_q ? ram_rd_ack : ram_wr_ack;
  assign cnt_inc   = cnt_q + LW'(1);
  assign last_word = (cnt_inc == len_q);
  assign remaining = (cnt_q != len_q);

  // Offset after one handshake. The stride register already holds the
  // effective (non-zero) increment.
`ifdef PSRAM_AGEN_WRAP_EN
  logic [OW:0] nxt;
  always_comb begin
    nxt     = {1'b0, off_q} + (OW+1)'(stride_q);
    off_adv = nxt[OW-1:0];
    if ((wrap_q != '0) && (nxt >= {1'b0, wrap_q})) begin
      off_adv = OW'(nxt - {1'b0, wrap_q});
    end
  end
`else
  always_comb begin
    off_adv = off_q + OW'(stride_q);
  end
`endif

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    saddr_d   = saddr_q;
    len_d     = len_q;
    stride_d  = stride_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    req_nxt   = req_cur;
    aborted_d = aborted_q;
    err_d     = 1'b0;
`ifdef PSRAM_AGEN_WRAP_EN
    wrap_d    = wrap_q;
`endif

    case (state_q)
      S_IDLE: begin
        req_nxt = 1'b0;
        if (start) begin
          if (len == '0) begin
            err_d = 1'b1;
          end else begin
            dir_d     = dir;
            saddr_d   = saddr;
            len_d     = len;
            stride_d  = (stride == '0) ? SW'(1) : stride;
`ifdef PSRAM_AGEN_WRAP_EN
            wrap_d    = wrap_len;
`endif
            off_d     = '0;
            cnt_d     = '0;
            aborted_d = 1'b0;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (req_cur) begin
          if (ack_cur) begin
            cnt_d = cnt_inc;
            off_d = off_adv;
            // The final handshake wins over a coincident abort.
            if (last_word) begin
              req_nxt = 1'b0;
              state_d = S_DONE;
            end else if (abort) begin
              req_nxt   = 1'b0;
              aborted_d = 1'b1;
              state_d   = S_DONE;
            end else begin
              req_nxt = buf_rdy;
            end
          end else if (abort) begin
            // Outstanding request must complete before stopping.
            state_d = S_DRAIN;
          end
        end else begin
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = S_DONE;
          end else if (buf_rdy && remaining) begin
            req_nxt = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (ack_cur) begin
          cnt_d     = cnt_inc;
          off_d     = off_adv;
          req_nxt   = 1'b0;
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        req_nxt = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        req_nxt = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    rd_req_d = req_nxt & dir_d;
    wr_req_d = req_nxt & ~dir_d;
    addr_d   = saddr_d + AW'(off_d);
    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    // DONE always falls back to IDLE, so this is a single-cycle pulse.
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      saddr_q   <= '0;
      len_q     <= '0;
      stride_q  <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef PSRAM_AGEN_WRAP_EN
      wrap_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      saddr_q   <= saddr_d;
      len_q     <= len_d;
      stride_q  <= stride_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
`ifdef PSRAM_AGEN_WRAP_EN
      wrap_q    <= wrap_d;
`endif
    end
  end

  assign ram_rd_req = rd_req_q;
  assign ram_wr_req = wr_req_q;
  assign ram_addr   = addr_q;
  assign xfer_cnt   = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign err        = err_q;

endmodule

`default_nettype wire
